vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 18 +
 rtl/rise_detect.sv | 24 ++
 rtl/vga_timing.sv | 92 +++++++++
 tb/tb_vga_timing.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate width, reused by the sprite and renderer blocks.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a slow square wave sampled as data in the clk domain.
// The history register resets high so a level already high at reset release
// is not mistaken for a fresh rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic q;

  // Previous-cycle copy of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b1;
    end else begin
      q <= d;
    end
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Counters advance once per rising edge of the
// pixel-rate vga_clk (sampled as data); sync and blanking are decoded from
// the next-counter values so they line up with pixel_x/pixel_y.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vga_clk,
  output logic               pix_stb,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam coord_t V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam coord_t H_VIS    = COORD_W'(H_VISIBLE);
  localparam coord_t V_VIS    = COORD_W'(V_VISIBLE);
  localparam coord_t HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic   adv;
  coord_t x_nxt;
  coord_t y_nxt;
  logic   wrap_frame;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vga_clk),
    .pulse (adv)
  );

  // Next raster position: x wraps at end of line, y steps on x wrap and wraps at end of frame.
  always_comb begin
    x_nxt = pixel_x + 1'b1;
    y_nxt = pixel_y;
    if (pixel_x == H_LAST) begin
      x_nxt = '0;
      if (pixel_y == V_LAST) begin
        y_nxt = '0;
      end else begin
        y_nxt = pixel_y + 1'b1;
      end
    end
  end

  assign wrap_frame = (pixel_x == H_LAST) && (pixel_y == V_LAST);

  // Counters and decoded outputs update only on a detected vga_clk rise.
  // Reset parks the raster on the last position so the first advance lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_stb     <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
    end else begin
      pix_stb     <= adv;
      frame_start <= adv && wrap_frame;
      if (adv) begin
        pixel_x  <= x_nxt;
        pixel_y  <= y_nxt;
        hsync    <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vsync    <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
        video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. Instance A uses the 640x480 defaults, B is a
// mid-size raster for the mid-frame reset scenario, C is a tiny raster so a
// complete frame can be walked quickly.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A: default timing
  logic rst_a, vga_a, stb_a, hs_a, vs_a, von_a, fs_a;
  logic [9:0] x_a, y_a;
  // Instance B: 336 x 110 raster
  logic rst_b, vga_b, stb_b, hs_b, vs_b, von_b, fs_b;
  logic [9:0] x_b, y_b;
  // Instance C: 16 x 10 raster
  logic rst_c, vga_c, stb_c, hs_c, vs_c, von_c, fs_c;
  logic [9:0] x_c, y_c;

  vga_timing dut_a (
    .clk(clk), .rst_n(rst_a), .vga_clk(vga_a), .pix_stb(stb_a),
    .pixel_x(x_a), .pixel_y(y_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .frame_start(fs_a)
  );

  vga_timing #(
    .H_VISIBLE(320), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(104), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .vga_clk(vga_b), .pix_stb(stb_b),
    .pixel_x(x_b), .pixel_y(y_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .frame_start(fs_b)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_c), .vga_clk(vga_c), .pix_stb(stb_c),
    .pixel_x(x_c), .pixel_y(y_c), .hsync(hs_c), .vsync(vs_c),
    .video_on(von_c), .frame_start(fs_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 4-clk vga_clk period on A; got = pix_stb seen one clk after the sampled rise.
  task automatic pix_a(output logic got);
    vga_a = 1'b0;
    tick();
    tick();
    vga_a = 1'b1;
    tick();
    got = stb_a;
    tick();
  endtask

  // One 2-clk vga_clk period on B; returns at the sample where pix_stb should be high.
  task automatic pix_b();
    vga_b = 1'b0;
    tick();
    vga_b = 1'b1;
    tick();
  endtask

  task automatic pix_c();
    vga_c = 1'b0;
    tick();
    vga_c = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int stb_seen;
    rst_a = 1'b0;
    vga_a = 1'b1;
    repeat (3) tick();
    total_cnt++; if (x_a !== 10'd799) $display("FAIL rst_x got %0d exp 799", x_a); else pass_cnt++;
    total_cnt++; if (y_a !== 10'd524) $display("FAIL rst_y got %0d exp 524", y_a); else pass_cnt++;
    total_cnt++; if (hs_a !== 1'b1) $display("FAIL rst_hsync got %b exp 1", hs_a); else pass_cnt++;
    total_cnt++; if (vs_a !== 1'b1) $display("FAIL rst_vsync got %b exp 1", vs_a); else pass_cnt++;
    total_cnt++; if (von_a !== 1'b0) $display("FAIL rst_video_on got %b exp 0", von_a); else pass_cnt++;
    total_cnt++; if (stb_a !== 1'b0) $display("FAIL rst_pix_stb got %b exp 0", stb_a); else pass_cnt++;
    total_cnt++; if (fs_a !== 1'b0) $display("FAIL rst_frame_start got %b exp 0", fs_a); else pass_cnt++;
    rst_a = 1'b1;
    stb_seen = 0;
    repeat (20) begin
      tick();
      if (stb_a) stb_seen++;
    end
    total_cnt++; if (stb_seen !== 0) $display("FAIL high_at_release_stb got %0d exp 0", stb_seen); else pass_cnt++;
    total_cnt++; if (x_a !== 10'd799) $display("FAIL high_at_release_x got %0d exp 799", x_a); else pass_cnt++;
    total_cnt++; if (y_a !== 10'd524) $display("FAIL high_at_release_y got %0d exp 524", y_a); else pass_cnt++;
  endtask

  task automatic test_first_advance();
    vga_a = 1'b0;
    tick();
    tick();
    vga_a = 1'b1;
    total_cnt++; if (stb_a !== 1'b0) $display("FAIL first_stb_early got %b exp 0", stb_a); else pass_cnt++;
    tick();
    total_cnt++; if (stb_a !== 1'b1) $display("FAIL first_stb got %b exp 1", stb_a); else pass_cnt++;
    total_cnt++; if (fs_a !== 1'b1) $display("FAIL first_frame_start got %b exp 1", fs_a); else pass_cnt++;
    total_cnt++; if (x_a !== 10'd0 || y_a !== 10'd0)
      $display("FAIL first_pos got (%0d,%0d) exp (0,0)", x_a, y_a); else pass_cnt++;
    total_cnt++; if (von_a !== 1'b1) $display("FAIL first_video_on got %b exp 1", von_a); else pass_cnt++;
    total_cnt++; if (hs_a !== 1'b1 || vs_a !== 1'b1)
      $display("FAIL first_sync got hs=%b vs=%b exp 1 1", hs_a, vs_a); else pass_cnt++;
    tick();
    total_cnt++; if (stb_a !== 1'b0 || fs_a !== 1'b0)
      $display("FAIL first_pulse_width got stb=%b fs=%b exp 0 0", stb_a, fs_a); else pass_cnt++;
  endtask

  task automatic test_hsync();
    logic got;
    int   exp_x;
    int   err;
    exp_x = 0;
    err   = 0;
    for (int i = 1; i <= 752; i++) begin
      pix_a(got);
      exp_x++;
      if (!got || x_a !== 10'(exp_x) || y_a !== 10'd0) err++;
      if (i == 639) begin
        total_cnt++; if (von_a !== 1'b1) $display("FAIL video_on_639 got %b exp 1", von_a); else pass_cnt++;
      end
      if (i == 640) begin
        total_cnt++; if (von_a !== 1'b0) $display("FAIL video_on_640 got %b exp 0", von_a); else pass_cnt++;
      end
      if (i == 655) begin
        total_cnt++; if (hs_a !== 1'b1) $display("FAIL hsync_655 got %b exp 1", hs_a); else pass_cnt++;
      end
      if (i == 656) begin
        total_cnt++; if (hs_a !== 1'b0) $display("FAIL hsync_656 got %b exp 0", hs_a); else pass_cnt++;
      end
      if (i == 751) begin
        total_cnt++; if (hs_a !== 1'b0) $display("FAIL hsync_751 got %b exp 0", hs_a); else pass_cnt++;
      end
      if (i == 752) begin
        total_cnt++; if (hs_a !== 1'b1) $display("FAIL hsync_752 got %b exp 1", hs_a); else pass_cnt++;
      end
    end
    total_cnt++; if (err !== 0) $display("FAIL line_walk errors got %0d exp 0", err); else pass_cnt++;
  endtask

  task automatic test_stretch();
    int cnt;
    vga_a = 1'b0;
    tick();
    tick();
    vga_a = 1'b1;
    cnt = 0;
    repeat (50) begin
      tick();
      if (stb_a) cnt++;
    end
    total_cnt++; if (cnt !== 1) $display("FAIL stretch_stb_count got %0d exp 1", cnt); else pass_cnt++;
    total_cnt++; if (x_a !== 10'd753) $display("FAIL stretch_x got %0d exp 753", x_a); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int fs_cnt, vs_cnt, hs_cnt, von_cnt, err;
    int exp_x, exp_y;
    rst_c = 1'b1;
    tick();
    pix_c();
    total_cnt++; if (fs_c !== 1'b1 || x_c !== 10'd0 || y_c !== 10'd0)
      $display("FAIL frame_first got fs=%b (%0d,%0d) exp 1 (0,0)", fs_c, x_c, y_c); else pass_cnt++;
    fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; von_cnt = 0; err = 0;
    exp_x = 0; exp_y = 0;
    for (int i = 1; i <= 160; i++) begin
      pix_c();
      if (exp_x == 15) begin
        exp_x = 0;
        exp_y = (exp_y == 9) ? 0 : exp_y + 1;
      end else begin
        exp_x++;
      end
      if (!stb_c || x_c !== 10'(exp_x) || y_c !== 10'(exp_y)) err++;
      if (fs_c) fs_cnt++;
      if (!vs_c) vs_cnt++;
      if (!hs_c) hs_cnt++;
      if (von_c) von_cnt++;
    end
    total_cnt++; if (err !== 0) $display("FAIL frame_walk errors got %0d exp 0", err); else pass_cnt++;
    total_cnt++; if (fs_cnt !== 1) $display("FAIL frame_start_count got %0d exp 1", fs_cnt); else pass_cnt++;
    total_cnt++; if (vs_cnt !== 32) $display("FAIL vsync_low_count got %0d exp 32", vs_cnt); else pass_cnt++;
    total_cnt++; if (hs_cnt !== 30) $display("FAIL hsync_low_count got %0d exp 30", hs_cnt); else pass_cnt++;
    total_cnt++; if (von_cnt !== 48) $display("FAIL video_on_count got %0d exp 48", von_cnt); else pass_cnt++;
    total_cnt++; if (fs_c !== 1'b1 || x_c !== 10'd0 || y_c !== 10'd0)
      $display("FAIL next_frame got fs=%b (%0d,%0d) exp 1 (0,0)", fs_c, x_c, y_c); else pass_cnt++;
  endtask

  task automatic test_mid_frame_reset();
    int guard;
    int stb_seen;
    rst_b = 1'b1;
    tick();
    guard = 0;
    while (!(x_b == 10'd300 && y_b == 10'd100) && guard < 40000) begin
      pix_b();
      guard++;
    end
    total_cnt++; if (x_b !== 10'd300 || y_b !== 10'd100)
      $display("FAIL reach_300_100 got (%0d,%0d) exp (300,100) after %0d", x_b, y_b, guard); else pass_cnt++;
    total_cnt++; if (von_b !== 1'b1 || hs_b !== 1'b1 || vs_b !== 1'b1 || stb_b !== 1'b1)
      $display("FAIL pre_reset got von=%b hs=%b vs=%b stb=%b exp 1 1 1 1", von_b, hs_b, vs_b, stb_b); else pass_cnt++;
    rst_b = 1'b0;
    #1;
    total_cnt++; if (x_b !== 10'd335 || y_b !== 10'd109)
      $display("FAIL async_rst_pos got (%0d,%0d) exp (335,109)", x_b, y_b); else pass_cnt++;
    total_cnt++; if (hs_b !== 1'b1 || vs_b !== 1'b1 || von_b !== 1'b0)
      $display("FAIL async_rst_sync got hs=%b vs=%b von=%b exp 1 1 0", hs_b, vs_b, von_b); else pass_cnt++;
    total_cnt++; if (stb_b !== 1'b0 || fs_b !== 1'b0)
      $display("FAIL async_rst_pulses got stb=%b fs=%b exp 0 0", stb_b, fs_b); else pass_cnt++;
    tick();
    tick();
    rst_b = 1'b1;
    stb_seen = 0;
    repeat (5) begin
      tick();
      if (stb_b) stb_seen++;
    end
    total_cnt++; if (stb_seen !== 0) $display("FAIL b_high_at_release got %0d exp 0", stb_seen); else pass_cnt++;
    pix_b();
    total_cnt++; if (fs_b !== 1'b1 || x_b !== 10'd0 || y_b !== 10'd0)
      $display("FAIL b_restart got fs=%b (%0d,%0d) exp 1 (0,0)", fs_b, x_b, y_b); else pass_cnt++;
  endtask

  initial begin
    rst_a = 1'b0; vga_a = 1'b1;
    rst_b = 1'b0; vga_b = 1'b1;
    rst_c = 1'b0; vga_c = 1'b1;
    test_reset();
    test_first_advance();
    test_hsync();
    test_stretch();
    test_full_frame();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
